field_merge_scheduler: RTL and testbench

- Index-ordered merge scheduler. Shares the single output byte FIFO between NUM_LANES encoder output lanes, for example the varint and raw-data encoded-byte FIFOs with their index sidecars.
- Emits the encoded fields of one message in ascending field index 0..field_count-1, moving whole fields without interleaving.
- Sits between the encoder output FIFOs (show-ahead) and the output FIFO that the AXI read FSM drains.

---
 rtl/fms_pkg.sv | 34 +++
 rtl/fms_lane_select.sv | 50 +++++
 rtl/field_merge_scheduler.sv | 166 ++++++++++++++++
 tb/tb_field_merge_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fms_pkg.sv
// rtl/fms_pkg.sv - shared types, constants and lane priority helper for the field merge scheduler
package fms_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Upper bound on lanes the priority helper can scan; instances use the low NUM_LANES bits.
    localparam int MAX_LANES       = 32;
    localparam int LANE_IDX_W      = $clog2(MAX_LANES);
    localparam int DEF_STALL_LIMIT = 1023;
    localparam int STALL_W         = $clog2(DEF_STALL_LIMIT + 1);

    typedef struct packed {
        logic                  found;
        logic [LANE_IDX_W-1:0] idx;
    } lane_hit_t;

    function automatic lane_hit_t lowest_match(input logic [MAX_LANES-1:0] match);
        lane_hit_t hit;
        hit.found = |match;
        hit.idx   = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit.idx = LANE_IDX_W'(i);
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/fms_lane_select.sv
// rtl/fms_lane_select.sv - index match, lowest-lane priority and granted-lane head mux
module fms_lane_select
    import fms_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int INDEX_W   = 10,
    parameter int DATA_W    = 8,
    parameter int LANE_W    = 1
) (
    input  logic [NUM_LANES-1:0]         lane_valid,
    input  logic [NUM_LANES*INDEX_W-1:0] lane_index,
    input  logic [NUM_LANES*DATA_W-1:0]  lane_data,
    input  logic [NUM_LANES-1:0]         lane_last,
    input  logic [INDEX_W-1:0]           expected,
    input  logic [LANE_W-1:0]            grant,
    output logic                         match_found,
    output logic [LANE_W-1:0]            match_lane,
    output logic                         sel_valid,
    output logic [DATA_W-1:0]            sel_data,
    output logic                         sel_last
);

    logic [MAX_LANES-1:0] match;
    lane_hit_t            hit;

    always_comb begin
        match = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            match[n] = lane_valid[n] && (lane_index[n*INDEX_W +: INDEX_W] == expected);
        end
    end

    assign hit         = lowest_match(match);
    assign match_found = hit.found;
    assign match_lane  = LANE_W'(hit.idx);

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (grant == LANE_W'(n)) begin
                sel_valid = lane_valid[n];
                sel_data  = lane_data[n*DATA_W +: DATA_W];
                sel_last  = lane_last[n];
            end
        end
    end

endmodule

// File: rtl/field_merge_scheduler.sv
// rtl/field_merge_scheduler.sv - merges encoder lanes into one output FIFO in ascending field index order
module field_merge_scheduler
    import fms_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int INDEX_W     = 10,
    parameter int DATA_W      = 8,
    parameter int STALL_LIMIT = 1023
) (
    input  logic                         clock_clk,
    input  logic                         reset_reset,
    input  logic                         msg_start,
    input  logic [INDEX_W-1:0]           msg_field_count,
    input  logic                         msg_abort,
    input  logic [NUM_LANES-1:0]         lane_valid,
    input  logic [NUM_LANES*INDEX_W-1:0] lane_index,
    input  logic [NUM_LANES*DATA_W-1:0]  lane_data,
    input  logic [NUM_LANES-1:0]         lane_last,
    output logic [NUM_LANES-1:0]         lane_pop,
    input  logic                         out_fifo_full,
    output logic                         out_fifo_push,
    output logic [DATA_W-1:0]            out_fifo_data,
    output logic                         busy,
    output logic                         msg_done,
    output logic                         error_stall
);

    localparam int                LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int                CNT_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = CNT_W'(STALL_LIMIT);

    state_t               state, state_nx;
    logic [INDEX_W-1:0]   fcount;
    logic [INDEX_W-1:0]   expected;
    logic [LANE_W-1:0]    grant;
    logic [CNT_W-1:0]     stall_cnt;
    logic                 error_q;
    logic                 done_q;
    logic [DATA_W-1:0]    data_q;

    logic                 match_found;
    logic [LANE_W-1:0]    match_lane;
    logic                 sel_valid;
    logic [DATA_W-1:0]    sel_data;
    logic                 sel_last;
    logic                 fire;
    logic                 last_field;

    fms_lane_select #(
        .NUM_LANES (NUM_LANES),
        .INDEX_W   (INDEX_W),
        .DATA_W    (DATA_W),
        .LANE_W    (LANE_W)
    ) u_lane_select (
        .lane_valid  (lane_valid),
        .lane_index  (lane_index),
        .lane_data   (lane_data),
        .lane_last   (lane_last),
        .expected    (expected),
        .grant       (grant),
        .match_found (match_found),
        .match_lane  (match_lane),
        .sel_valid   (sel_valid),
        .sel_data    (sel_data),
        .sel_last    (sel_last)
    );

    // Abort and reset both kill the transfer in the cycle they are seen.
    assign fire       = (state == XFER) && sel_valid && !out_fifo_full && !msg_abort && !reset_reset;
    // fcount is nonzero whenever this is consulted (only from XFER).
    assign last_field = (expected == (fcount - INDEX_W'(1)));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (msg_start) begin
                    state_nx = (msg_field_count == '0) ? DONE : SEEK;
                end
            end
            SEEK: begin
                if (match_found) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (fire && sel_last) begin
                    state_nx = last_field ? DONE : SEEK;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (msg_abort) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state     <= IDLE;
            fcount    <= '0;
            expected  <= '0;
            grant     <= '0;
            stall_cnt <= '0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state  <= state_nx;
            done_q <= (state == DONE) && !msg_abort;
            if (fire) begin
                data_q <= sel_data;
            end
            if (msg_abort) begin
                expected  <= '0;
                stall_cnt <= '0;
                error_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (msg_start) begin
                            fcount    <= msg_field_count;
                            expected  <= '0;
                            stall_cnt <= '0;
                            error_q   <= 1'b0;
                        end
                    end
                    SEEK: begin
                        if (match_found) begin
                            grant     <= match_lane;
                            stall_cnt <= '0;
                        end else if (stall_cnt != STALL_MAX) begin
                            stall_cnt <= stall_cnt + CNT_W'(1);
                            if (stall_cnt == STALL_MAX - CNT_W'(1)) begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    XFER: begin
                        if (fire && sel_last && !last_field) begin
                            expected <= expected + INDEX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        lane_pop = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (fire && (grant == LANE_W'(n))) begin
                lane_pop[n] = 1'b1;
            end
        end
    end

    assign out_fifo_push = fire;
    assign out_fifo_data = fire ? sel_data : data_q;
    assign busy          = (state != IDLE);
    assign msg_done      = done_q;
    assign error_stall   = error_q;

endmodule

// File: tb/tb_field_merge_scheduler.sv
// tb/tb_field_merge_scheduler.sv - self-checking bench for field_merge_scheduler
module tb_field_merge_scheduler;

    localparam int NUM_LANES   = 2;
    localparam int INDEX_W     = 10;
    localparam int DATA_W      = 8;
    localparam int STALL_LIMIT = 8;

    logic                         clk = 1'b0;
    logic                         reset_reset;
    logic                         msg_start;
    logic [INDEX_W-1:0]           msg_field_count;
    logic                         msg_abort;
    logic [NUM_LANES-1:0]         lane_valid;
    logic [NUM_LANES*INDEX_W-1:0] lane_index;
    logic [NUM_LANES*DATA_W-1:0]  lane_data;
    logic [NUM_LANES-1:0]         lane_last;
    logic [NUM_LANES-1:0]         lane_pop;
    logic                         out_fifo_full;
    logic                         out_fifo_push;
    logic [DATA_W-1:0]            out_fifo_data;
    logic                         busy;
    logic                         msg_done;
    logic                         error_stall;

    field_merge_scheduler #(
        .NUM_LANES   (NUM_LANES),
        .INDEX_W     (INDEX_W),
        .DATA_W      (DATA_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clock_clk       (clk),
        .reset_reset     (reset_reset),
        .msg_start       (msg_start),
        .msg_field_count (msg_field_count),
        .msg_abort       (msg_abort),
        .lane_valid      (lane_valid),
        .lane_index      (lane_index),
        .lane_data       (lane_data),
        .lane_last       (lane_last),
        .lane_pop        (lane_pop),
        .out_fifo_full   (out_fifo_full),
        .out_fifo_push   (out_fifo_push),
        .out_fifo_data   (out_fifo_data),
        .busy            (busy),
        .msg_done        (msg_done),
        .error_stall     (error_stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [INDEX_W-1:0] idx;
        logic [7:0]         data;
        logic               last;
    } lbyte_t;

    typedef struct packed {
        logic [3:0]            fcount;
        logic [2:0]            f_lane;
        logic [2:0][1:0]       f_len;
        logic [2:0][2:0][7:0]  f_data;
        logic [31:0]           full_mask;
        logic [3:0]            exp_len;
        logic [7:0][7:0]       exp_out;
    } vec_t;

    lbyte_t              lq [NUM_LANES][$];
    logic [7:0]          exp_q[$];
    logic [7:0]          got_q[$];
    logic [NUM_LANES-1:0] drv_valid;

    int n_pass = 0;
    int n_total = 0;
    int avail_pct = 100;
    int full_pct = 0;
    logic use_mask = 1'b0;
    logic [31:0] full_mask = '0;
    int cyc_k = 0;
    int n_done = 0;
    int done_k = -1;

    logic                 obs_push, obs_busy, obs_done, obs_err;
    logic [NUM_LANES-1:0] obs_pop;
    logic [7:0]           obs_data;

    task automatic check(input string name, input logic cond, input longint act, input longint exp);
        n_total++;
        if (cond) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_lanes();
        for (int n = 0; n < NUM_LANES; n++) begin
            drv_valid[n] = (lq[n].size() > 0) && (int'($urandom_range(0, 99)) < avail_pct);
            if (drv_valid[n]) begin
                lane_index[n*INDEX_W +: INDEX_W] = lq[n][0].idx;
                lane_data[n*DATA_W +: DATA_W]    = lq[n][0].data;
                lane_last[n]                     = lq[n][0].last;
            end else begin
                lane_index[n*INDEX_W +: INDEX_W] = INDEX_W'($urandom);
                lane_data[n*DATA_W +: DATA_W]    = DATA_W'($urandom);
                lane_last[n]                     = 1'($urandom);
            end
        end
        lane_valid = drv_valid;
    endtask

    task automatic observe();
        logic ok;
        int   l;
        obs_push = out_fifo_push;
        obs_pop  = lane_pop;
        obs_data = out_fifo_data;
        obs_busy = busy;
        obs_done = msg_done;
        obs_err  = error_stall;
        if (out_fifo_push) begin
            ok = $onehot(lane_pop);
            l  = 0;
            for (int n = 0; n < NUM_LANES; n++) if (lane_pop[n]) l = n;
            if (!drv_valid[l] || lq[l].size() == 0) ok = 1'b0;
            else if (lq[l][0].data != out_fifo_data) ok = 1'b0;
            got_q.push_back(out_fifo_data);
        end else begin
            ok = (lane_pop == '0);
        end
        check("pop_vs_push", ok, lane_pop, out_fifo_push);
        check("push_when_full", !(out_fifo_push && out_fifo_full), out_fifo_push, 0);
    endtask

    task automatic cycle();
        drive_lanes();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (obs_pop[n] && lq[n].size() > 0) void'(lq[n].pop_front());
        end
        msg_start = 1'b0;
        msg_abort = 1'b0;
    endtask

    task automatic step();
        if (use_mask) out_fifo_full = (cyc_k < 32) ? full_mask[cyc_k] : 1'b0;
        else          out_fifo_full = (int'($urandom_range(0, 99)) < full_pct);
        cycle();
        if (obs_done) begin
            n_done++;
            if (done_k < 0) done_k = cyc_k;
        end
        cyc_k++;
    endtask

    task automatic begin_msg(input int fcount);
        got_q.delete();
        n_done          = 0;
        done_k          = -1;
        cyc_k           = 0;
        msg_start       = 1'b1;
        msg_field_count = INDEX_W'(fcount);
    endtask

    task automatic finish_msg(input int budget);
        int   guard;
        int   bad;
        logic ok;
        guard = 0;
        while (guard < budget && !(done_k >= 0 && cyc_k > done_k + 2)) begin
            step();
            guard++;
        end
        check("done_pulses", n_done == 1, n_done, 1);
        check("stream_len", got_q.size() == exp_q.size(), got_q.size(), exp_q.size());
        ok  = 1'b1;
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (ok && got_q[i] != exp_q[i]) begin
                ok  = 1'b0;
                bad = i;
            end
        end
        check("stream_data", ok, ok ? 0 : got_q[bad], ok ? 0 : exp_q[bad]);
        check("lanes_drained", lq[0].size() + lq[1].size() == 0, lq[0].size() + lq[1].size(), 0);
    endtask

    task automatic push_byte(input int lane, input int idx, input logic [7:0] d, input logic last);
        lbyte_t e;
        e.idx  = INDEX_W'(idx);
        e.data = d;
        e.last = last;
        lq[lane].push_back(e);
    endtask

    task automatic clear_lanes();
        for (int n = 0; n < NUM_LANES; n++) lq[n].delete();
    endtask

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0].fcount    = 4'd3;
        vecs[0].f_lane    = 3'b010;
        vecs[0].f_len     = {2'd2, 2'd3, 2'd3};
        vecs[0].f_data    = {8'h00, 8'h05, 8'h10, 8'h42, 8'h41, 8'h0A, 8'h01, 8'h96, 8'h08};
        vecs[0].full_mask = 32'h0;
        vecs[0].exp_len   = 4'd8;
        vecs[0].exp_out   = {8'h05, 8'h10, 8'h42, 8'h41, 8'h0A, 8'h01, 8'h96, 8'h08};
        vecs[1]           = vecs[0];
        vecs[1].full_mask = 32'h0000_0F80;
        vecs[2].fcount    = 4'd1;
        vecs[2].f_lane    = 3'b001;
        vecs[2].f_len     = {2'd0, 2'd0, 2'd2};
        vecs[2].f_data    = {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h00, 8'hBB, 8'hAA};
        vecs[2].full_mask = 32'h0000_0AA8;
        vecs[2].exp_len   = 4'd2;
        vecs[2].exp_out   = {8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'hBB, 8'hAA};
        vecs[3]           = '0;

        reset_reset     = 1'b1;
        msg_start       = 1'b0;
        msg_abort       = 1'b0;
        msg_field_count = '0;
        out_fifo_full   = 1'b0;
        lane_valid      = '0;
        lane_index      = '0;
        lane_data       = '0;
        lane_last       = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();
        check("rst_busy", obs_busy == 1'b0, obs_busy, 0);
        check("rst_push", obs_push == 1'b0, obs_push, 0);
        check("rst_pop", obs_pop == '0, obs_pop, 0);
        check("rst_data", obs_data == 8'h00, obs_data, 0);
        check("rst_done", obs_done == 1'b0, obs_done, 0);
        check("rst_err", obs_err == 1'b0, obs_err, 0);
        reset_reset = 1'b0;
        cycle();

        // Directed message table.
        use_mask  = 1'b1;
        avail_pct = 100;
        for (int v = 0; v < 4; v++) begin
            clear_lanes();
            exp_q.delete();
            for (int f = 0; f < int'(vecs[v].fcount); f++) begin
                for (int b = 0; b < int'(vecs[v].f_len[f]); b++) begin
                    push_byte(int'(vecs[v].f_lane[f]), f, vecs[v].f_data[f][b],
                              b == int'(vecs[v].f_len[f]) - 1);
                end
            end
            for (int i = 0; i < int'(vecs[v].exp_len); i++) exp_q.push_back(vecs[v].exp_out[i]);
            full_mask = vecs[v].full_mask;
            begin_msg(int'(vecs[v].fcount));
            finish_msg(80);
            check("push_count", got_q.size() == int'(vecs[v].exp_len), got_q.size(), vecs[v].exp_len);
            if (vecs[v].fcount == 4'd0) check("empty_done_latency", done_k == 2, done_k, 2);
        end
        use_mask = 1'b0;
        full_pct = 0;

        // Tie-break: both lanes offer index 0, lane 0 wins, lane 1 is never touched.
        clear_lanes();
        push_byte(0, 0, 8'h11, 1'b1);
        push_byte(1, 0, 8'h22, 1'b1);
        begin_msg(2);
        step(); step(); step();
        check("tie_pop", obs_pop == 2'b01, obs_pop, 1);
        check("tie_data", obs_data == 8'h11, obs_data, 8'h11);
        step(); step();
        check("tie_lane1_kept", lq[1].size() == 1, lq[1].size(), 1);
        msg_abort = 1'b1;
        step();
        step();
        check("tie_abort_idle", obs_busy == 1'b0, obs_busy, 0);
        clear_lanes();

        // Stall: only index 1 present while index 0 is expected.
        push_byte(1, 1, 8'h33, 1'b1);
        exp_q.delete();
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h33);
        begin_msg(2);
        for (int i = 0; i < 9; i++) step();
        check("stall_not_yet", obs_err == 1'b0, obs_err, 0);
        step();
        check("stall_flag", obs_err == 1'b1, obs_err, 1);
        check("stall_still_busy", obs_busy == 1'b1, obs_busy, 1);
        push_byte(0, 0, 8'h44, 1'b1);
        finish_msg(60);
        check("stall_sticky", obs_err == 1'b1, obs_err, 1);
        exp_q.delete();
        begin_msg(0);
        step();
        step();
        check("stall_cleared", obs_err == 1'b0, obs_err, 0);
        finish_msg(20);

        // Abort on the second byte of a field.
        clear_lanes();
        push_byte(0, 0, 8'h01, 1'b0);
        push_byte(0, 0, 8'h02, 1'b0);
        push_byte(0, 0, 8'h03, 1'b1);
        begin_msg(1);
        step(); step(); step();
        msg_abort = 1'b1;
        step();
        check("abort_no_push", obs_push == 1'b0 && obs_pop == '0, obs_push, 0);
        check("abort_data_hold", obs_data == 8'h01, obs_data, 8'h01);
        step();
        check("abort_idle", obs_busy == 1'b0, obs_busy, 0);
        check("abort_lane_kept", lq[0].size() == 2, lq[0].size(), 2);

        // Reset on the second byte of a field.
        clear_lanes();
        push_byte(0, 0, 8'h01, 1'b0);
        push_byte(0, 0, 8'h02, 1'b0);
        push_byte(0, 0, 8'h03, 1'b1);
        begin_msg(1);
        step(); step(); step();
        reset_reset = 1'b1;
        step();
        check("reset_no_push", obs_push == 1'b0 && obs_pop == '0, obs_push, 0);
        reset_reset = 1'b0;
        step();
        check("reset_busy", obs_busy == 1'b0, obs_busy, 0);
        check("reset_data", obs_data == 8'h00 && obs_push == 1'b0, obs_data, 0);
        check("reset_flags", obs_done == 1'b0 && obs_err == 1'b0, {obs_done, obs_err}, 0);
        clear_lanes();

        // Random messages against the index-ordered concatenation model.
        avail_pct = 75;
        full_pct  = 25;
        for (int m = 0; m < 6; m++) begin
            int fc;
            exp_q.delete();
            fc = int'($urandom_range(1, 6));
            for (int f = 0; f < fc; f++) begin
                int lane;
                int len;
                lane = int'($urandom_range(0, NUM_LANES - 1));
                len  = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    push_byte(lane, f, d, b == len - 1);
                    exp_q.push_back(d);
                end
            end
            begin_msg(fc);
            finish_msg(400);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
